// File: rtl/tlight_monitor.sv
// Passive checker for the ns/we traffic-light bus: tracks phase order and durations, reports coded violations.
// Optional error counter output enabled by defining TLIGHT_MONITOR_ERRCNT_EN.
package tlight_pkg;
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } tlight_control_t;
endpackage

module tlight_monitor
  import tlight_pkg::*;
#(
  parameter int unsigned ALL_RED_CYCLES     = 1,
  parameter int unsigned PRE_YELLOW_CYCLES  = 3,
  parameter int unsigned GREEN_CYCLES       = 15,
  parameter int unsigned POST_YELLOW_CYCLES = 1,
  parameter int unsigned CNT_W              = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ns,
  input  logic [1:0]  we,
  output logic        locked,
  output logic        error,
  output logic [2:0]  error_code,
  output logic        error_sticky,
  output logic [15:0] cycle_count
`ifdef TLIGHT_MONITOR_ERRCNT_EN
  ,
  output logic [7:0]  error_count
`endif
);

  typedef enum logic [3:0] {
    S_START,
    S_ALL_RED,
    S_WE_PRE,
    S_WE_GREEN,
    S_WE_POST,
    S_NS_PRE,
    S_NS_GREEN,
    S_NS_POST,
    S_SYNC
  } state_t;

  typedef enum logic [2:0] {
    E_NONE     = 3'd0,
    E_CONFLICT = 3'd1,
    E_SEQ      = 3'd2,
    E_SHORT    = 3'd3,
    E_LONG     = 3'd4
  } err_t;

  localparam logic [3:0] C_RR = {RED, RED};
  localparam logic [3:0] C_RY = {RED, YELLOW};
  localparam logic [3:0] C_RG = {RED, GREEN};
  localparam logic [3:0] C_YR = {YELLOW, RED};
  localparam logic [3:0] C_GR = {GREEN, RED};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic [3:0]        prev_q, prev_d;
  logic              locked_q, locked_d;
  logic              error_q, error_d;
  err_t              error_code_q, error_code_d;
  logic              error_sticky_q, error_sticky_d;
  logic [15:0]       cycle_count_q, cycle_count_d;

  logic [3:0]        cur;
  logic [3:0]        phase_combo;
  logic [3:0]        next_combo;
  logic [CNT_W-1:0]  phase_len;
  logic [CNT_W-1:0]  run_inc;
  state_t            next_state;

  always_comb begin
    cur         = {ns, we};
    phase_combo = C_RR;
    next_combo  = C_RR;
    phase_len   = '0;
    next_state  = S_SYNC;
    case (state_q)
      S_ALL_RED:  begin phase_combo = C_RR; phase_len = CNT_W'(ALL_RED_CYCLES);
                        next_combo = C_RY; next_state = S_WE_PRE;   end
      S_WE_PRE:   begin phase_combo = C_RY; phase_len = CNT_W'(PRE_YELLOW_CYCLES);
                        next_combo = C_RG; next_state = S_WE_GREEN; end
      S_WE_GREEN: begin phase_combo = C_RG; phase_len = CNT_W'(GREEN_CYCLES);
                        next_combo = C_RY; next_state = S_WE_POST;  end
      S_WE_POST:  begin phase_combo = C_RY; phase_len = CNT_W'(POST_YELLOW_CYCLES);
                        next_combo = C_YR; next_state = S_NS_PRE;   end
      S_NS_PRE:   begin phase_combo = C_YR; phase_len = CNT_W'(PRE_YELLOW_CYCLES);
                        next_combo = C_GR; next_state = S_NS_GREEN; end
      S_NS_GREEN: begin phase_combo = C_GR; phase_len = CNT_W'(GREEN_CYCLES);
                        next_combo = C_YR; next_state = S_NS_POST;  end
      S_NS_POST:  begin phase_combo = C_YR; phase_len = CNT_W'(POST_YELLOW_CYCLES);
                        next_combo = C_RY; next_state = S_WE_PRE;   end
      default: ;
    endcase
  end

  // Saturating run length so a stuck bus can never wrap back into a legal count.
  assign run_inc = (run_q == '1) ? run_q : run_q + CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    run_d          = run_q;
    prev_d         = cur;
    error_d        = 1'b0;
    error_code_d   = error_code_q;
    error_sticky_d = error_sticky_q;
    cycle_count_d  = cycle_count_q;

    if (ns != RED && we != RED) begin
      error_d      = 1'b1;
      error_code_d = E_CONFLICT;
    end else if (state_q == S_START) begin
      if (cur == C_RR) begin
        state_d = S_ALL_RED;
        run_d   = CNT_W'(1);
      end else begin
        error_d      = 1'b1;
        error_code_d = E_SEQ;
      end
    end else if (state_q == S_SYNC) begin
      if (prev_q == C_RY && cur == C_RG) begin
        state_d = S_WE_GREEN;
        run_d   = CNT_W'(1);
      end else if (prev_q == C_YR && cur == C_GR) begin
        state_d = S_NS_GREEN;
        run_d   = CNT_W'(1);
      end
    end else if (cur == phase_combo) begin
      if (run_inc > phase_len) begin
        error_d      = 1'b1;
        error_code_d = E_LONG;
      end else begin
        run_d = run_inc;
      end
    end else if (cur == next_combo) begin
      if (run_q < phase_len) begin
        error_d      = 1'b1;
        error_code_d = E_SHORT;
      end else begin
        state_d = next_state;
        run_d   = CNT_W'(1);
        if (state_q == S_NS_POST) cycle_count_d = cycle_count_q + 16'd1;
      end
    end else begin
      error_d      = 1'b1;
      error_code_d = E_SEQ;
    end

    if (error_d) begin
      state_d        = S_SYNC;
      run_d          = '0;
      error_sticky_d = 1'b1;
    end

    locked_d = !(state_d == S_START || state_d == S_SYNC);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_START;
      run_q          <= '0;
      prev_q         <= C_RR;
      locked_q       <= 1'b0;
      error_q        <= 1'b0;
      error_code_q   <= E_NONE;
      error_sticky_q <= 1'b0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      prev_q         <= prev_d;
      locked_q       <= locked_d;
      error_q        <= error_d;
      error_code_q   <= error_code_d;
      error_sticky_q <= error_sticky_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign locked       = locked_q;
  assign error        = error_q;
  assign error_code   = error_code_q;
  assign error_sticky = error_sticky_q;
  assign cycle_count  = cycle_count_q;

`ifdef TLIGHT_MONITOR_ERRCNT_EN
  logic [7:0] error_count_q, error_count_d;

  always_comb begin
    error_count_d = error_count_q;
    if (error_d && error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) error_count_q <= '0;
    else        error_count_q <= error_count_d;
  end

  assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_tlight_monitor.sv
// Directed, table-driven bench for tlight_monitor; covers the error counter when TLIGHT_MONITOR_ERRCNT_EN is defined.
module tb_tlight_monitor;

  localparam logic [1:0] R = tlight_pkg::RED;
  localparam logic [1:0] Y = tlight_pkg::YELLOW;
  localparam logic [1:0] G = tlight_pkg::GREEN;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  ns = R;
  logic [1:0]  we = R;
  logic        locked;
  logic        error;
  logic [2:0]  error_code;
  logic        error_sticky;
  logic [15:0] cycle_count;
`ifdef TLIGHT_MONITOR_ERRCNT_EN
  logic [7:0]  error_count;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  tlight_monitor #(
    .ALL_RED_CYCLES    (1),
    .PRE_YELLOW_CYCLES (3),
    .GREEN_CYCLES      (15),
    .POST_YELLOW_CYCLES(1),
    .CNT_W             (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ns          (ns),
    .we          (we),
    .locked      (locked),
    .error       (error),
    .error_code  (error_code),
    .error_sticky(error_sticky),
    .cycle_count (cycle_count)
`ifdef TLIGHT_MONITOR_ERRCNT_EN
    ,
    .error_count (error_count)
`endif
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [1:0]  ns;
    logic [1:0]  we;
    logic        locked;
    logic        error;
    logic [2:0]  code;
    logic        sticky;
    logic [15:0] cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic [1:0] n, input logic [1:0] w,
                     input logic l, input logic e, input logic [2:0] c, input logic s,
                     input logic [15:0] cy, input int unsigned reps = 1);
    vec_t v;
    v.name = nm; v.rst_n = r; v.ns = n; v.we = w; v.locked = l;
    v.error = e; v.code = c; v.sticky = s; v.cyc = cy;
    for (int unsigned i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] n, input logic [1:0] w);
    reset = r; ns = n; we = w;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset and two legal full cycles.
    add("rst", 0, R, R, 0, 0, 0, 0, 0);
    add("all_red", 1, R, R, 1, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      add("we_pre",  1, R, Y, 1, 0, 0, 0, 16'(r), 3);
      add("we_grn",  1, R, G, 1, 0, 0, 0, 16'(r), 15);
      add("we_post", 1, R, Y, 1, 0, 0, 0, 16'(r), 1);
      add("ns_pre",  1, Y, R, 1, 0, 0, 0, 16'(r), 3);
      add("ns_grn",  1, G, R, 1, 0, 0, 0, 16'(r), 15);
      add("ns_post", 1, Y, R, 1, 0, 0, 0, 16'(r), 1);
    end
    add("cyc2",     1, R, Y, 1, 0, 0, 0, 2);
    add("we_pre2",  1, R, Y, 1, 0, 0, 0, 2, 2);
    add("we_grn4",  1, R, G, 1, 0, 0, 0, 2, 4);
    // Conflict at green run 5, then re-lock on the next green onset.
    add("conflict", 1, G, G, 0, 1, 1, 1, 2);
    add("sync_ry",  1, R, Y, 0, 0, 1, 1, 2);
    add("relock",   1, R, G, 1, 0, 1, 1, 2);
    // Short green (10 samples).
    add("grn10",    1, R, G, 1, 0, 1, 1, 2, 9);
    add("short",    1, R, Y, 0, 1, 3, 1, 2);
    add("sync_yr",  1, Y, R, 0, 0, 3, 1, 2);
    add("lock_ns",  1, G, R, 1, 0, 3, 1, 2);
    add("ns_grn",   1, G, R, 1, 0, 3, 1, 2, 14);
    add("ns_post",  1, Y, R, 1, 0, 3, 1, 2);
    // Long pre-yellow: fourth R,Y sample.
    add("cyc3",     1, R, Y, 1, 0, 3, 1, 3);
    add("we_pre",   1, R, Y, 1, 0, 3, 1, 3, 2);
    add("long_pre", 1, R, Y, 0, 1, 4, 1, 3);
    // Sequence violation from WE_GREEN; sticky survives a later legal cycle.
    add("lock_we",  1, R, G, 1, 0, 4, 1, 3);
    add("seq",      1, Y, R, 0, 1, 2, 1, 3);
    add("sync",     1, R, Y, 0, 0, 2, 1, 3);
    add("lock",     1, R, G, 1, 0, 2, 1, 3);
    add("we_grn",   1, R, G, 1, 0, 2, 1, 3, 14);
    add("we_post",  1, R, Y, 1, 0, 2, 1, 3);
    add("ns_pre",   1, Y, R, 1, 0, 2, 1, 3, 3);
    add("ns_grn",   1, G, R, 1, 0, 2, 1, 3, 15);
    add("ns_post",  1, Y, R, 1, 0, 2, 1, 3);
    add("cyc4",     1, R, Y, 1, 0, 2, 1, 4);
    // Reset, then a bad first sample goes to SYNC.
    add("rst2",     0, G, R, 0, 0, 0, 0, 0);
    add("first_ry", 1, R, Y, 0, 1, 2, 1, 0);
    add("lock5",    1, R, G, 1, 0, 2, 1, 0);
    add("grn15",    1, R, G, 1, 0, 2, 1, 0, 14);
    add("grn_long", 1, R, G, 0, 1, 4, 1, 0);
    // Reset mid NS_GREEN.
    add("sync_yr2", 1, Y, R, 0, 0, 4, 1, 0);
    add("lock_ns2", 1, G, R, 1, 0, 4, 1, 0);
    add("ns_grn",   1, G, R, 1, 0, 4, 1, 0, 4);
    add("rst_mid",  0, G, R, 0, 0, 0, 0, 0);
    add("all_red2", 1, R, R, 1, 0, 0, 0, 0);
    add("red_long", 1, R, R, 0, 1, 4, 1, 0);
    // Back-to-back conflicts in SYNC each pulse.
    add("cf1",      1, G, Y, 0, 1, 1, 1, 0);
    add("cf2",      1, Y, Y, 0, 1, 1, 1, 0);
    add("cf3",      1, G, G, 0, 1, 1, 1, 0);
    add("sync_rr",  1, R, R, 0, 0, 1, 1, 0);
    // Conflict takes priority over the START check.
    add("rst3",     0, R, R, 0, 0, 0, 0, 0);
    add("start_cf", 1, Y, G, 0, 1, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].ns, vecs[i].we);
      check($sformatf("%s[%0d].locked", vecs[i].name, i), 16'(locked), 16'(vecs[i].locked));
      check($sformatf("%s[%0d].error", vecs[i].name, i), 16'(error), 16'(vecs[i].error));
      check($sformatf("%s[%0d].error_code", vecs[i].name, i), 16'(error_code), 16'(vecs[i].code));
      check($sformatf("%s[%0d].error_sticky", vecs[i].name, i), 16'(error_sticky), 16'(vecs[i].sticky));
      check($sformatf("%s[%0d].cycle_count", vecs[i].name, i), cycle_count, vecs[i].cyc);
    end

    // Reset overrides a simultaneous conflict on the bus.
    apply(1'b0, G, G);
    check("rst_over_cf.error", 16'(error), 16'd0);
    check("rst_over_cf.error_code", 16'(error_code), 16'd0);
    check("rst_over_cf.sticky", 16'(error_sticky), 16'd0);

`ifdef TLIGHT_MONITOR_ERRCNT_EN
    check("errcnt_rst", 16'(error_count), 16'd0);
    for (int k = 1; k <= 300; k++) begin
      apply(1'b1, G, G);
      check($sformatf("errcnt_pulse[%0d]", k), 16'(error), 16'd1);
      if (k == 1 || k == 254 || k == 255 || k == 300)
        check($sformatf("errcnt[%0d]", k), 16'(error_count), (k < 255) ? 16'(k) : 16'd255);
    end
    apply(1'b1, R, R);
    check("errcnt_held", 16'(error_count), 16'd255);
    apply(1'b0, R, R);
    check("errcnt_rst2", 16'(error_count), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
